axis_window_3x3: RTL and testbench

- Downstream stage of the video size detector: consumes the same AXI-Stream pixel stream plus the detected `video_width` / `video_size_valid`.
- Emits one 3x3 pixel neighbourhood per valid window position as a single wide AXI-Stream beat, for the convolution engine.
- Uses two internal line buffers and a 3x3 shift array.
- No border padding: only fully populated windows are output.

---
 rtl/axis_window_3x3.sv | 187 ++++++++++++++++++
 tb/tb_axis_window_3x3.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_window_3x3.sv
// axis_window_3x3
// Builds 3x3 pixel neighbourhoods from an AXI-Stream video line stream and
// emits each fully populated window as one wide beat for the convolution
// engine. Two line buffers hold the previous two lines and a 3x3 shift array
// holds the sliding window; the shift array doubles as the output data
// register because it only moves on an accepted pixel, which cannot happen
// while a beat is stalled downstream.

module axis_window_3x3 #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WIDTH  = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tuser,
   input  logic [31:0]             video_width,
   input  logic                    video_size_valid,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [9*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tuser,
   output logic                    m_axis_tlast,
   output logic                    line_err
);

   localparam int ADDR_W = $clog2(MAX_WIDTH);
   localparam int COL_W  = ADDR_W + 1;
   localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(MAX_WIDTH);
   localparam logic [COL_W-1:0] COL_TWO   = COL_W'(2);

   logic [COL_W-1:0]      col;
   logic [15:0]           row;
   logic [31:0]           cfg_width;

   logic [DATA_WIDTH-1:0] lb0 [MAX_WIDTH];
   logic [DATA_WIDTH-1:0] lb1 [MAX_WIDTH];
   logic [DATA_WIDTH-1:0] win [3][3];

   logic                  accept;
   logic [COL_W-1:0]      col_eff;
   logic [15:0]           row_eff;
   logic [31:0]           cfg_eff;
   logic [31:0]           col_ext;
   logic [ADDR_W-1:0]     addr;
   logic                  in_range;
   logic                  check_en;
   logic                  last_bad;
   logic                  forced_end;
   logic                  line_end;
   logic                  err_set;
   logic                  emit;
   logic                  first_win;
   logic [COL_W-1:0]      col_next;
   logic [15:0]           row_next;
   logic [DATA_WIDTH-1:0] lb0_rd;
   logic [DATA_WIDTH-1:0] lb1_rd;
   logic [DATA_WIDTH-1:0] new_col [3];

   assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
   assign accept        = s_axis_tvalid && s_axis_tready;

   // A start-of-frame pixel restarts the position counters and reloads the
   // trusted width for itself, so every decision below uses the "effective"
   // values that already account for a tuser on the current pixel.
   always_comb begin
      col_eff = col;
      row_eff = row;
      cfg_eff = cfg_width;
      if (s_axis_tuser) begin
         col_eff = '0;
         row_eff = '0;
         cfg_eff = video_size_valid ? video_width : 32'd0;
      end
   end

   // Line-length bookkeeping: detect short/long lines against the configured
   // width, treat a line that reaches the configured width as ended even
   // without tlast, and stop buffering once the line outgrows the RAMs.
   always_comb begin
      col_ext    = 32'(col_eff);
      addr       = col_eff[ADDR_W-1:0];
      in_range   = (col_eff < COL_LIMIT);
      check_en   = (cfg_eff != 32'd0);
      last_bad   = check_en && s_axis_tlast && (col_ext != cfg_eff - 32'd1);
      forced_end = check_en && !s_axis_tlast && (col_ext + 32'd1 == cfg_eff);
      line_end   = s_axis_tlast || forced_end;
      err_set    = last_bad || forced_end || !in_range;
      emit       = in_range && (row_eff >= 16'd2) && (col_eff >= COL_TWO);
      first_win  = (row_eff == 16'd2) && (col_eff == COL_TWO);
      col_next   = col_eff;
      row_next   = row_eff;
      if (line_end) begin
         col_next = '0;
         row_next = (row_eff == 16'hFFFF) ? row_eff : row_eff + 16'd1;
      end else if (in_range) begin
         col_next = col_eff + COL_W'(1);
      end
   end

   // The line buffers are read asynchronously so the incoming column is
   // complete in the same cycle the pixel is accepted; the write happens on
   // the clock edge, so a same-address read always sees the old contents.
   always_comb begin
      lb0_rd     = lb0[addr];
      lb1_rd     = lb1[addr];
      new_col[0] = lb1_rd;
      new_col[1] = lb0_rd;
      new_col[2] = s_axis_tdata;
   end

   // Flatten the shift array into the output word, oldest row and leftmost
   // column in the least significant pixel slot.
   always_comb begin
      m_axis_tdata = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            m_axis_tdata[(3*r+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
         end
      end
   end

   // Age each column position by one line: the previous line moves into lb1
   // and the current pixel becomes the previous line in lb0. Columns beyond
   // the buffer depth are never written.
   always_ff @(posedge clk) begin
      if (accept && in_range) begin
         lb1[addr] <= lb0_rd;
         lb0[addr] <= s_axis_tdata;
      end
   end

   // Slide the window one column left on every accepted pixel and insert the
   // new column on the right; cleared on reset so the idle output word is 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
            win[r][2] <= new_col[r];
         end
      end
   end

   // Position counters, latched frame width and the sticky line error, which
   // a new frame clears before its own first pixel is judged.
   always_ff @(posedge clk) begin
      if (reset) begin
         col       <= '0;
         row       <= '0;
         cfg_width <= '0;
         line_err  <= 1'b0;
      end else if (accept) begin
         col       <= col_next;
         row       <= row_next;
         cfg_width <= cfg_eff;
         line_err  <= (s_axis_tuser ? 1'b0 : line_err) | err_set;
      end
   end

   // Output beat control: a new window raises valid one cycle after its last
   // pixel is accepted; a drained beat drops valid unless a new window is
   // loaded in the same cycle, which gives back-to-back beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else if (accept && emit) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tuser  <= first_win;
         m_axis_tlast  <= s_axis_tlast;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_window_3x3.sv
// tb_axis_window_3x3
// Directed bench for axis_window_3x3: drives small frames with pixel value
// 16*row+col and compares collected output beats against windows computed
// from that pixel formula.

module tb_axis_window_3x3;

   localparam int DW = 8;

   typedef struct packed {
      logic          user;
      logic          last;
      logic [9*DW-1:0] data;
   } beat_t;

   logic            clk;
   logic            reset;
   logic            s_tvalid;
   logic            s_tready;
   logic [DW-1:0]   s_tdata;
   logic            s_tlast;
   logic            s_tuser;
   logic [31:0]     video_width;
   logic            video_size_valid;
   logic            m_tvalid;
   logic            m_tready;
   logic [9*DW-1:0] m_tdata;
   logic            m_tuser;
   logic            m_tlast;
   logic            line_err;

   int     checkCount = 0;
   int     passCount  = 0;
   int     stallErrs  = 0;
   int     readyMode  = 0;
   int     patIdx     = 0;
   logic [3:0] patBits = 4'b1001;
   beat_t  beats[$];

   axis_window_3x3 #(.DATA_WIDTH(DW), .MAX_WIDTH(1024)) dut (
      .clk              (clk),
      .reset            (reset),
      .s_axis_tvalid    (s_tvalid),
      .s_axis_tready    (s_tready),
      .s_axis_tdata     (s_tdata),
      .s_axis_tlast     (s_tlast),
      .s_axis_tuser     (s_tuser),
      .video_width      (video_width),
      .video_size_valid (video_size_valid),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tready    (m_tready),
      .m_axis_tdata     (m_tdata),
      .m_axis_tuser     (m_tuser),
      .m_axis_tlast     (m_tlast),
      .line_err         (line_err)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream ready: always high, the 1-0-0-1 pattern, or held low.
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            1: begin
               m_tready = patBits[patIdx];
               patIdx   = (patIdx + 1) % 4;
            end
            2:       m_tready = 1'b0;
            default: m_tready = 1'b1;
         endcase
      end
   end

   // Record every beat that transfers on the coming edge and watch the
   // input-ready relation on every cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (m_tvalid && m_tready) beats.push_back({m_tuser, m_tlast, m_tdata});
         if (s_tready !== (!m_tvalid || m_tready)) stallErrs++;
      end
   end

   // Expected k-th window of a frame w pixels wide with pixel = 16*row+col.
   function automatic beat_t exp_beat(input int w, input int k);
      beat_t b;
      int bigR;
      int bigC;
      bigR = 2 + k / (w - 2);
      bigC = 2 + k % (w - 2);
      b.data = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            b.data[(3*r+c)*DW +: DW] = DW'(16 * (bigR - 2 + r) + (bigC - 2 + c));
         end
      end
      b.user = (k == 0);
      b.last = (bigC == w - 1);
      return b;
   endfunction

   // Offer one pixel and hold it until the DUT accepts it.
   task automatic applyStimulus(input int r, input int c, input bit last, input bit user);
      int waited;
      waited   = 0;
      s_tvalid = 1'b1;
      s_tdata  = DW'(16 * r + c);
      s_tlast  = last;
      s_tuser  = user;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         waited++;
         if (waited > 200) begin
            checkCount++;
            $display("[TB] FAIL accept_timeout pixel r=%0d c=%0d: s_axis_tready stayed 0, required 1", r, c);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic send_frame(input int w, input int h);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            applyStimulus(r, c, c == w - 1, (r == 0) && (c == 0));
         end
      end
   endtask

   task automatic drain();
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      s_tvalid         = 1'b0;
      s_tdata          = '0;
      s_tlast          = 1'b0;
      s_tuser          = 1'b0;
      video_width      = 32'd5;
      video_size_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkCount++;
      if (m_tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid got %b want 0", m_tvalid);
      else passCount++;
      checkCount++;
      if ({m_tuser, m_tlast} !== 2'b00) $display("[TB] FAIL reset_tuser_tlast got %b want 00", {m_tuser, m_tlast});
      else passCount++;
      checkCount++;
      if (m_tdata !== '0) $display("[TB] FAIL reset_tdata got %h want 0", m_tdata);
      else passCount++;
      checkCount++;
      if (line_err !== 1'b0) $display("[TB] FAIL reset_line_err got %b want 0", line_err);
      else passCount++;
      checkCount++;
      if (s_tready !== 1'b1) $display("[TB] FAIL reset_s_tready got %b want 1", s_tready);
      else passCount++;
   endtask

   task automatic test_basic_frame();
      readyMode = 0;
      video_width = 32'd5;
      video_size_valid = 1'b1;
      beats.delete();
      send_frame(5, 4);
      drain();
      checkCount++;
      if (beats.size() != 6) $display("[TB] FAIL basic_count got %0d want 6", beats.size());
      else passCount++;
      for (int k = 0; k < 6; k++) begin
         checkCount++;
         if (k >= beats.size()) $display("[TB] FAIL basic_beat%0d missing, want %h", k, exp_beat(5, k));
         else if (beats[k] !== exp_beat(5, k))
            $display("[TB] FAIL basic_beat%0d got %h want %h", k, beats[k], exp_beat(5, k));
         else passCount++;
      end
      checkCount++;
      if (line_err !== 1'b0) $display("[TB] FAIL basic_line_err got %b want 0", line_err);
      else passCount++;
   endtask

   task automatic test_back_to_back();
      readyMode = 1;
      stallErrs = 0;
      beats.delete();
      send_frame(5, 4);
      drain();
      readyMode = 0;
      checkCount++;
      if (beats.size() != 6) $display("[TB] FAIL bp_count got %0d want 6", beats.size());
      else passCount++;
      for (int k = 0; k < 6; k++) begin
         checkCount++;
         if (k >= beats.size()) $display("[TB] FAIL bp_beat%0d missing, want %h", k, exp_beat(5, k));
         else if (beats[k] !== exp_beat(5, k))
            $display("[TB] FAIL bp_beat%0d got %h want %h", k, beats[k], exp_beat(5, k));
         else passCount++;
      end
      checkCount++;
      if (stallErrs != 0) $display("[TB] FAIL bp_s_tready_rule got %0d bad cycles want 0", stallErrs);
      else passCount++;
   endtask

   task automatic test_line_err();
      readyMode = 0;
      video_width = 32'd5;
      video_size_valid = 1'b1;
      for (int c = 0; c < 5; c++) applyStimulus(0, c, c == 4, c == 0);
      checkCount++;
      if (line_err !== 1'b0) $display("[TB] FAIL lerr_before got %b want 0", line_err);
      else passCount++;
      for (int c = 0; c < 4; c++) applyStimulus(1, c, c == 3, 1'b0);
      checkCount++;
      if (line_err !== 1'b1) $display("[TB] FAIL lerr_short_line got %b want 1", line_err);
      else passCount++;
      beats.delete();
      applyStimulus(0, 0, 1'b0, 1'b1);
      checkCount++;
      if (line_err !== 1'b0) $display("[TB] FAIL lerr_cleared got %b want 0", line_err);
      else passCount++;
      for (int c = 1; c < 5; c++) applyStimulus(0, c, c == 4, 1'b0);
      for (int r = 1; r < 4; r++)
         for (int c = 0; c < 5; c++) applyStimulus(r, c, c == 4, 1'b0);
      drain();
      checkCount++;
      if (beats.size() != 6) $display("[TB] FAIL lerr_next_count got %0d want 6", beats.size());
      else passCount++;
   endtask

   task automatic test_small_frames();
      readyMode = 0;
      beats.delete();
      video_width = 32'd2;
      send_frame(2, 2);
      drain();
      checkCount++;
      if (beats.size() != 0) $display("[TB] FAIL small_2x2_count got %0d want 0", beats.size());
      else passCount++;
      checkCount++;
      if (line_err !== 1'b0) $display("[TB] FAIL small_2x2_err got %b want 0", line_err);
      else passCount++;
      video_width = 32'd3;
      send_frame(3, 3);
      drain();
      checkCount++;
      if (beats.size() != 1) $display("[TB] FAIL small_3x3_count got %0d want 1", beats.size());
      else passCount++;
      checkCount++;
      if (beats.size() < 1) $display("[TB] FAIL small_3x3_beat missing, want %h", exp_beat(3, 0));
      else if (beats[0] !== exp_beat(3, 0))
         $display("[TB] FAIL small_3x3_beat got %h want %h", beats[0], exp_beat(3, 0));
      else passCount++;
   endtask

   task automatic test_abort();
      readyMode = 0;
      video_width = 32'd5;
      beats.delete();
      for (int c = 0; c < 5; c++) applyStimulus(0, c, c == 4, c == 0);
      for (int c = 0; c < 3; c++) applyStimulus(1, c, 1'b0, 1'b0);
      send_frame(5, 4);
      drain();
      checkCount++;
      if (beats.size() != 6) $display("[TB] FAIL abort_count got %0d want 6", beats.size());
      else passCount++;
      for (int k = 0; k < 6; k++) begin
         checkCount++;
         if (k >= beats.size()) $display("[TB] FAIL abort_beat%0d missing, want %h", k, exp_beat(5, k));
         else if (beats[k] !== exp_beat(5, k))
            $display("[TB] FAIL abort_beat%0d got %h want %h", k, beats[k], exp_beat(5, k));
         else passCount++;
      end
      checkCount++;
      if (line_err !== 1'b0) $display("[TB] FAIL abort_line_err got %b want 0", line_err);
      else passCount++;
   endtask

   task automatic test_reset_stall();
      readyMode = 2;
      video_width = 32'd5;
      @(posedge clk);
      #1;
      send_frame(3, 3);
      @(posedge clk);
      #1;
      checkCount++;
      if (m_tvalid !== 1'b1) $display("[TB] FAIL rst_stall_pending got %b want 1", m_tvalid);
      else passCount++;
      checkCount++;
      if (line_err !== 1'b1) $display("[TB] FAIL rst_stall_err_set got %b want 1", line_err);
      else passCount++;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkCount++;
      if (m_tvalid !== 1'b0) $display("[TB] FAIL rst_stall_tvalid got %b want 0", m_tvalid);
      else passCount++;
      checkCount++;
      if (line_err !== 1'b0) $display("[TB] FAIL rst_stall_line_err got %b want 0", line_err);
      else passCount++;
      readyMode = 0;
      beats.delete();
      @(posedge clk);
      #1;
      send_frame(5, 4);
      drain();
      checkCount++;
      if (beats.size() != 6) $display("[TB] FAIL rst_after_count got %0d want 6", beats.size());
      else passCount++;
      for (int k = 0; k < 6; k++) begin
         checkCount++;
         if (k >= beats.size()) $display("[TB] FAIL rst_after_beat%0d missing, want %h", k, exp_beat(5, k));
         else if (beats[k] !== exp_beat(5, k))
            $display("[TB] FAIL rst_after_beat%0d got %h want %h", k, beats[k], exp_beat(5, k));
         else passCount++;
      end
   endtask

   // Run every scenario in order and report.
   initial begin
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_line_err();
      test_small_frames();
      test_abort();
      test_reset_stall();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
